// File: rtl/imem_cache.sv
`default_nettype none
// ============================================================================
// Module   : imem_cache
// Brief    : Instruction-side responder for the fetch stage. A direct-mapped
//            cache of one-word lines answers fetch requests; misses are
//            refilled from backing instruction memory over a req/ack
//            handshake while fetch is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module imem_cache #(
  parameter int INDEX_W = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_con_Req,
  input  logic [31:0] i_addr_PC,
  input  logic        i_con_Flush,
  output logic [31:0] o_data_Instr,
  output logic        o_con_Valid,
  output logic        o_con_Stall,
  output logic        o_con_MemReq,
  output logic [31:0] o_addr_Mem,
  input  logic        i_con_MemAck,
  input  logic [31:0] i_data_Mem
);

  localparam int NLINES = 1 << INDEX_W;
  localparam int TAG_W  = 30 - INDEX_W;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_REFILL = 1'b1
  } state_t;

  // Control state
  state_t              state_q, state_d;
  logic                flush_pend_q, flush_pend_d;
  logic [31:0]         instr_q, instr_d;
  logic                valid_out_q, valid_out_d;
  logic                memreq_q, memreq_d;
  logic [31:0]         addr_q, addr_d;

  // Line storage
  logic [NLINES-1:0]   line_valid_q, line_valid_d;
  logic [TAG_W-1:0]    line_tag_q  [NLINES];
  logic [31:0]         line_data_q [NLINES];

  // Lookup against the incoming PC
  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic                w_hit;

  // Refill target, taken from the registered refill address
  logic [INDEX_W-1:0]  w_refill_idx;
  logic [TAG_W-1:0]    w_refill_tag;
  logic                w_refill_wr;
  logic                w_refill_valid;

  // Byte-offset bits of the PC carry no information for word fetches
  logic [1:0]          w_unused_pc_bits;

  assign w_unused_pc_bits = i_addr_PC[1:0];

  assign w_idx = i_addr_PC[INDEX_W+1:2];
  assign w_tag = i_addr_PC[31:INDEX_W+2];
  assign w_hit = line_valid_q[w_idx] && (line_tag_q[w_idx] == w_tag);

  assign w_refill_idx   = addr_q[INDEX_W+1:2];
  assign w_refill_tag   = addr_q[31:INDEX_W+2];
  assign w_refill_wr    = (state_q == S_REFILL) && i_con_MemAck;
  // A flush seen at any point during the refill (including the ack cycle)
  // leaves the refilled line invalid.
  assign w_refill_valid = ~(flush_pend_q | i_con_Flush);

  assign o_con_Stall  = (state_q == S_REFILL) ||
                        ((state_q == S_IDLE) && i_con_Req && !w_hit);
  assign o_data_Instr = instr_q;
  assign o_con_Valid  = valid_out_q;
  assign o_con_MemReq = memreq_q;
  assign o_addr_Mem   = addr_q;

  // Next-state and output-register logic for the lookup/refill FSM
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    instr_d      = instr_q;
    valid_out_d  = 1'b0;
    memreq_d     = memreq_q;
    addr_d       = addr_q;
    case (state_q)
      S_IDLE: begin
        flush_pend_d = 1'b0;
        memreq_d     = 1'b0;
        if (i_con_Req) begin
          if (w_hit) begin
            instr_d     = line_data_q[w_idx];
            valid_out_d = 1'b1;
          end else begin
            addr_d   = {i_addr_PC[31:2], 2'b00};
            memreq_d = 1'b1;
            state_d  = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        memreq_d = 1'b1;
        if (i_con_Flush) begin
          flush_pend_d = 1'b1;
        end
        if (i_con_MemAck) begin
          instr_d      = i_data_Mem;
          valid_out_d  = 1'b1;
          memreq_d     = 1'b0;
          flush_pend_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Valid-bit update: refill write first, then flush clears everything
  always_comb begin
    line_valid_d = line_valid_q;
    if (w_refill_wr) begin
      line_valid_d[w_refill_idx] = w_refill_valid;
    end
    if (i_con_Flush) begin
      line_valid_d = '0;
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      flush_pend_q <= 1'b0;
      instr_q      <= 32'h0;
      valid_out_q  <= 1'b0;
      memreq_q     <= 1'b0;
      addr_q       <= 32'h0;
      line_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      instr_q      <= instr_d;
      valid_out_q  <= valid_out_d;
      memreq_q     <= memreq_d;
      addr_q       <= addr_d;
      line_valid_q <= line_valid_d;
    end
  end

  // Tag and data arrays: payload only, qualified by the valid bits
  generate
    for (genvar i = 0; i < NLINES; i++) begin : g_line
      // Overwrite this line when a refill for its index completes
      always_ff @(posedge i_clk) begin
        if (w_refill_wr && (w_refill_idx == INDEX_W'(i))) begin
          line_tag_q[i]  <= w_refill_tag;
          line_data_q[i] <= i_data_Mem;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_imem_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_cache
// Brief    : Directed self-checking bench for imem_cache (INDEX_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_cache;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] instr;
  logic        valid;
  logic        stall;
  logic        memreq;
  logic [31:0] memaddr;
  logic        ack;
  logic [31:0] memdata;

  int passed = 0;
  int total  = 0;

  imem_cache #(.INDEX_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_con_Req    (req),
    .i_addr_PC    (pc),
    .i_con_Flush  (flush),
    .o_data_Instr (instr),
    .o_con_Valid  (valid),
    .o_con_Stall  (stall),
    .o_con_MemReq (memreq),
    .o_addr_Mem   (memaddr),
    .i_con_MemAck (ack),
    .i_data_Mem   (memdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: miss on address a, ack one cycle after MemReq rises.
  // On return the Valid/Instr of the refill are on the outputs.
  task automatic serve_miss(input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; pc = a;
    tick();
    ack = 1'b1; memdata = d;
    tick();
    ack = 1'b0; req = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; pc = 32'h0; flush = 1'b0; ack = 1'b0; memdata = 32'h0;
    #2;
    total++;
    if ({instr, valid, memreq, memaddr, stall} !== 98'h0) begin
      $display("FAIL reset_outputs: got instr=%h valid=%b memreq=%b addr=%h stall=%b, need all 0",
               instr, valid, memreq, memaddr, stall);
    end else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    req = 1'b1; pc = 32'h0;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL reset_cold_stall: got %b need 1", stall);
    else passed++;
    req = 1'b0;
    #1;
  endtask

  task automatic test_cold_miss();
    int scnt;
    scnt = 0;
    req = 1'b1; pc = 32'h0000_0040;
    #1;
    if (stall) scnt++;
    total++;
    if (memreq !== 1'b0) $display("FAIL miss_memreq_c0: got %b need 0", memreq);
    else passed++;
    tick();
    if (stall) scnt++;
    total++;
    if (memreq !== 1'b1 || memaddr !== 32'h40)
      $display("FAIL miss_memreq_c1: got memreq=%b addr=%h need 1/00000040", memreq, memaddr);
    else passed++;
    tick();
    if (stall) scnt++;
    tick();
    if (stall) scnt++;
    ack = 1'b1; memdata = 32'h2002_0005;
    tick();
    ack = 1'b0; req = 1'b0;
    #1;
    total++;
    if (valid !== 1'b1 || instr !== 32'h2002_0005)
      $display("FAIL miss_deliver: got valid=%b instr=%h need 1/20020005", valid, instr);
    else passed++;
    total++;
    if (stall !== 1'b0 || memreq !== 1'b0)
      $display("FAIL miss_release: got stall=%b memreq=%b need 0/0", stall, memreq);
    else passed++;
    total++;
    if (scnt !== 4) $display("FAIL miss_stall_cycles: got %0d need 4", scnt);
    else passed++;
    tick();
    total++;
    if (valid !== 1'b0) $display("FAIL miss_valid_pulse: got %b need 0", valid);
    else passed++;
  endtask

  task automatic test_hit();
    req = 1'b1; pc = 32'h40;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL hit_stall: got %b need 0", stall);
    else passed++;
    tick();
    pc = 32'h42;
    #1;
    total++;
    if (valid !== 1'b1 || instr !== 32'h2002_0005 || memreq !== 1'b0)
      $display("FAIL hit_40: got valid=%b instr=%h memreq=%b need 1/20020005/0", valid, instr, memreq);
    else passed++;
    total++;
    if (stall !== 1'b0) $display("FAIL hit_42_stall: got %b need 0", stall);
    else passed++;
    tick();
    req = 1'b0;
    #1;
    total++;
    if (valid !== 1'b1 || instr !== 32'h2002_0005)
      $display("FAIL hit_42: got valid=%b instr=%h need 1/20020005", valid, instr);
    else passed++;
    tick();
    total++;
    if (valid !== 1'b0) $display("FAIL hit_idle_valid: got %b need 0", valid);
    else passed++;
  endtask

  task automatic test_conflict();
    req = 1'b1; pc = 32'h0;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL conflict_00_cold: got stall=%b need 1", stall);
    else passed++;
    serve_miss(32'h0, 32'hAAAA_0000);
    total++;
    if (valid !== 1'b1 || instr !== 32'hAAAA_0000)
      $display("FAIL conflict_00_fill: got valid=%b instr=%h need 1/aaaa0000", valid, instr);
    else passed++;
    tick();
    req = 1'b1; pc = 32'h40;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL conflict_40_evicted: got stall=%b need 1", stall);
    else passed++;
    serve_miss(32'h40, 32'h2002_0005);
    tick();
    req = 1'b1; pc = 32'h0;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL conflict_00_evicted: got stall=%b need 1", stall);
    else passed++;
    req = 1'b0;
    #1;
  endtask

  task automatic test_flush_idle();
    serve_miss(32'h48, 32'h1111_2222);
    tick();
    req = 1'b1; pc = 32'h48; flush = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL flush_idle_prehit: got stall=%b need 0", stall);
    else passed++;
    tick();
    flush = 1'b0;
    #1;
    total++;
    if (valid !== 1'b1 || instr !== 32'h1111_2222)
      $display("FAIL flush_idle_served: got valid=%b instr=%h need 1/11112222", valid, instr);
    else passed++;
    total++;
    if (stall !== 1'b1) $display("FAIL flush_idle_after: got stall=%b need 1", stall);
    else passed++;
    req = 1'b0;
    #1;
  endtask

  task automatic test_flush_refill();
    serve_miss(32'h44, 32'h4444_0044);
    tick();
    serve_miss(32'h40, 32'h2002_0005);
    tick();
    req = 1'b1; pc = 32'h80;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    total++;
    if (memreq !== 1'b1 || memaddr !== 32'h80)
      $display("FAIL flushr_memreq: got memreq=%b addr=%h need 1/00000080", memreq, memaddr);
    else passed++;
    ack = 1'b1; memdata = 32'h8888_0080;
    tick();
    ack = 1'b0; req = 1'b0;
    #1;
    total++;
    if (valid !== 1'b1 || instr !== 32'h8888_0080)
      $display("FAIL flushr_deliver: got valid=%b instr=%h need 1/88880080", valid, instr);
    else passed++;
    tick();
    req = 1'b1; pc = 32'h80;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL flushr_80_miss: got stall=%b need 1", stall);
    else passed++;
    pc = 32'h44;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL flushr_44_miss: got stall=%b need 1", stall);
    else passed++;
    pc = 32'h40;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL flushr_40_miss: got stall=%b need 1", stall);
    else passed++;
    req = 1'b0;
    #1;
    // The refill after a clean flush must leave the line valid again
    serve_miss(32'h80, 32'h8888_0081);
    tick();
    req = 1'b1; pc = 32'h80;
    #1;
    total++;
    if (stall !== 1'b0) $display("FAIL flushr_refill_valid: got stall=%b need 0", stall);
    else passed++;
    req = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    req = 1'b1; pc = 32'h100;
    tick();
    ack = 1'b1; memdata = 32'h0100_0100;
    tick();
    ack = 1'b0; pc = 32'h104;
    #1;
    total++;
    if (valid !== 1'b1 || instr !== 32'h0100_0100 || memreq !== 1'b0)
      $display("FAIL b2b_min_latency: got valid=%b instr=%h memreq=%b need 1/01000100/0",
               valid, instr, memreq);
    else passed++;
    total++;
    if (stall !== 1'b1) $display("FAIL b2b_second_stall: got %b need 1", stall);
    else passed++;
    tick();
    total++;
    if (memreq !== 1'b1 || memaddr !== 32'h104 || valid !== 1'b0)
      $display("FAIL b2b_second_req: got memreq=%b addr=%h valid=%b need 1/00000104/0",
               memreq, memaddr, valid);
    else passed++;
    ack = 1'b1; memdata = 32'h0104_0104;
    tick();
    ack = 1'b0; req = 1'b0;
    #1;
    total++;
    if (valid !== 1'b1 || instr !== 32'h0104_0104)
      $display("FAIL b2b_second_deliver: got valid=%b instr=%h need 1/01040104", valid, instr);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid_refill();
    req = 1'b1; pc = 32'h200;
    tick();
    total++;
    if (memreq !== 1'b1) $display("FAIL rstr_memreq_up: got %b need 1", memreq);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (memreq !== 1'b0 || memaddr !== 32'h0 || valid !== 1'b0 || instr !== 32'h0)
      $display("FAIL rstr_async: got memreq=%b addr=%h valid=%b instr=%h need all 0",
               memreq, memaddr, valid, instr);
    else passed++;
    req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    ack = 1'b1; memdata = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || memreq !== 1'b0 || instr !== 32'h0)
      $display("FAIL rstr_stray_ack: got valid=%b memreq=%b instr=%h need 0/0/0", valid, memreq, instr);
    else passed++;
    req = 1'b1; pc = 32'h200;
    #1;
    total++;
    if (stall !== 1'b1) $display("FAIL rstr_not_written: got stall=%b need 1", stall);
    else passed++;
    req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush_idle();
    test_flush_refill();
    test_back_to_back();
    test_reset_mid_refill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
